int_controller: RTL

- Interrupt source for the RISC core: the initiator side of the core's INT input.
- Collects up to NSRC external interrupt lines, synchronises them and edge-detects them.
- Latches pending bits, applies a software mask and raises INT for the highest-priority enabled request.
- Runs an INT/inta/eoi handshake with the core and supplies a vector (handler address) for the core to load into PC.

---
 rtl/int_ctrl_pkg.sv | 18 +
 rtl/irq_sync_edge.sv | 30 +++
 rtl/int_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Imported by the controller top and its edge-detect front end.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERV
  } state_t;

  localparam logic [1:0] ADDR_MASK  = 2'd0;
  localparam logic [1:0] ADDR_PEND  = 2'd1;
  localparam logic [1:0] ADDR_INSVC = 2'd2;
  localparam logic [1:0] ADDR_VBASE = 2'd3;

  localparam int ID_W = 5;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser plus a third flop for rising-edge detect.
// One pulse per rising edge of each asynchronous input line.
module irq_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: pending/mask/in-service registers, priority
// select and the INT/inta/eoi handshake supplying a handler vector.
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter int NSRC       = 8,
  parameter int VEC_STRIDE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic            inta,
  input  logic            eoi,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  output logic            INT,
  output logic [31:0]     vec,
  output logic [ID_W-1:0] irq_id
);

  state_t state;

  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] insvc;
  logic [31:0]     vbase;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] cur_oh;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] take_oh;
  logic [NSRC-1:0] done_oh;
  logic [ID_W-1:0] win_id;
  logic            any_req;
  logic            cur_req;
  logic            take;
  logic            done;

  irq_sync_edge #(
    .W (NSRC)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (irq),
    .rise (rise)
  );

  assign req     = pend & mask;
  assign any_req = |req;

  // Lowest index wins: scan high to low so the last hit sticks.
  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < NSRC; i++) begin
      cur_oh[i] = (irq_id == ID_W'(i));
    end
  end

  assign cur_req = |(req & cur_oh);
  assign take    = (state == REQ) && inta;
  assign done    = (state == SERV) && eoi;
  assign take_oh = take ? cur_oh : '0;
  assign done_oh = done ? cur_oh : '0;

  assign w1c = (cfg_we && cfg_addr == ADDR_PEND)
             ? cfg_wdata[NSRC-1:0] : '0;

  // A fresh edge is OR-ed in last so it beats both clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask  <= '0;
      pend  <= '0;
      insvc <= '0;
      vbase <= '0;
    end else begin
      pend  <= (pend & ~w1c & ~take_oh) | rise;
      insvc <= (insvc | take_oh) & ~done_oh;
      if (cfg_we && cfg_addr == ADDR_MASK)
        mask <= cfg_wdata[NSRC-1:0];
      if (cfg_we && cfg_addr == ADDR_VBASE)
        vbase <= {cfg_wdata[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      INT    <= 1'b0;
      vec    <= '0;
      irq_id <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            irq_id <= win_id;
            vec    <= vbase
                    + 32'(win_id) * 32'(VEC_STRIDE);
            INT    <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (inta) begin
            INT   <= 1'b0;
            state <= SERV;
          end else if (!cur_req) begin
            INT   <= 1'b0;
            state <= IDLE;
          end
        end
        SERV: begin
          if (eoi) state <= IDLE;
        end
        default: begin
          INT   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_rdata <= '0;
    end else begin
      unique case (cfg_addr)
        ADDR_MASK:  cfg_rdata <= 32'(mask);
        ADDR_PEND:  cfg_rdata <= 32'(pend);
        ADDR_INSVC: cfg_rdata <= 32'(insvc);
        ADDR_VBASE: cfg_rdata <= vbase;
        default:    cfg_rdata <= '0;
      endcase
    end
  end

endmodule
